// File: rtl/page_ram_wr_arb.sv
// rtl/page_ram_wr_arb.sv - round-robin burst write arbiter for a shared page RAM
// Grants one lane at a time for up to MAX_BURST beats; rd_lock only gates new grants.
module page_ram_wr_arb #(
  parameter  int N_LANE          = 2,
  parameter  int PAGE_RAM_ADDR_W = 9,
  parameter  int DATA_W          = 40,
  parameter  int MAX_BURST       = 16,
  parameter  int STALL_CNT_W     = 16,
  localparam int LANE_W          = (N_LANE > 1) ? $clog2(N_LANE) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_LANE-1:0]                 req_valid,
  input  logic [N_LANE-1:0]                 req_last,
  input  logic [N_LANE*PAGE_RAM_ADDR_W-1:0] req_addr,
  input  logic [N_LANE*DATA_W-1:0]          req_data,
  output logic [N_LANE-1:0]                 req_ready,
  input  logic                              rd_lock,
  output logic                              page_ram_we,
  output logic [PAGE_RAM_ADDR_W-1:0]        page_ram_wr_addr,
  output logic [DATA_W-1:0]                 page_ram_wr_data,
  output logic [LANE_W-1:0]                 grant_lane,
  output logic                              busy,
  output logic                              wr_blocked_by_rd_lock,
  output logic                              burst_err,
  output logic [N_LANE*STALL_CNT_W-1:0]     stall_cnt_flat
);

  localparam int BEAT_W = $clog2(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state;
  logic [LANE_W-1:0]      last_grant;
  logic [BEAT_W-1:0]      beat_cnt;
  logic [STALL_CNT_W-1:0] stall_cnt [N_LANE];

  logic [LANE_W-1:0]          sel;
  logic                       sel_found;
  logic                       g_valid;
  logic                       g_last;
  logic [PAGE_RAM_ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0]          g_data;
  logic                       beat;

  // Lanes above last_grant get first look; the second pass wraps to the lowest valid lane.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int i = 0; i < N_LANE; i++) begin
      if (!sel_found && req_valid[i] && (LANE_W'(i) > last_grant)) begin
        sel       = LANE_W'(i);
        sel_found = 1'b1;
      end
    end
    for (int i = 0; i < N_LANE; i++) begin
      if (!sel_found && req_valid[i]) begin
        sel       = LANE_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    g_valid   = 1'b0;
    g_last    = 1'b0;
    g_addr    = '0;
    g_data    = '0;
    for (int i = 0; i < N_LANE; i++) begin
      if (grant_lane == LANE_W'(i)) begin
        req_ready[i] = (state == BURST);
        g_valid      = req_valid[i];
        g_last       = req_last[i];
        g_addr       = req_addr[i*PAGE_RAM_ADDR_W +: PAGE_RAM_ADDR_W];
        g_data       = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign beat                  = (state == BURST) && g_valid;
  assign busy                  = (state == BURST);
  assign wr_blocked_by_rd_lock = (state == IDLE) && rd_lock && (|req_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      last_grant       <= LANE_W'(N_LANE - 1);
      grant_lane       <= '0;
      beat_cnt         <= '0;
      page_ram_we      <= 1'b0;
      page_ram_wr_addr <= '0;
      page_ram_wr_data <= '0;
      burst_err        <= 1'b0;
    end else begin
      page_ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (!rd_lock && sel_found) begin
            grant_lane <= sel;
            beat_cnt   <= '0;
            state      <= BURST;
          end
        end
        BURST: begin
          if (beat) begin
            page_ram_we      <= 1'b1;
            page_ram_wr_addr <= g_addr;
            page_ram_wr_data <= g_data;
            if (g_last) begin
              state      <= IDLE;
              last_grant <= grant_lane;
            end else if (beat_cnt == BEAT_W'(MAX_BURST - 1)) begin
              // A lane that never raises last is cut off so the others are not starved.
              state      <= IDLE;
              last_grant <= grant_lane;
              burst_err  <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_LANE; i++) stall_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_LANE; i++) begin
        if (req_valid[i] && !req_ready[i] && !(&stall_cnt[i])) begin
          stall_cnt[i] <= stall_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_flat = '0;
    for (int i = 0; i < N_LANE; i++) begin
      stall_cnt_flat[i*STALL_CNT_W +: STALL_CNT_W] = stall_cnt[i];
    end
  end

endmodule

// File: tb/tb_page_ram_wr_arb.sv
// tb/tb_page_ram_wr_arb.sv - directed vector bench for page_ram_wr_arb
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_page_ram_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_last;
  logic [17:0] req_addr;
  logic [79:0] req_data;
  logic [1:0]  req_ready;
  logic        rd_lock;
  logic        page_ram_we;
  logic [8:0]  page_ram_wr_addr;
  logic [39:0] page_ram_wr_data;
  logic        grant_lane;
  logic        busy;
  logic        wr_blocked_by_rd_lock;
  logic        burst_err;
  logic [31:0] stall_cnt_flat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  page_ram_wr_arb #(
    .N_LANE(2), .PAGE_RAM_ADDR_W(9), .DATA_W(40), .MAX_BURST(16), .STALL_CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rd_lock(rd_lock),
    .page_ram_we(page_ram_we), .page_ram_wr_addr(page_ram_wr_addr),
    .page_ram_wr_data(page_ram_wr_data), .grant_lane(grant_lane), .busy(busy),
    .wr_blocked_by_rd_lock(wr_blocked_by_rd_lock), .burst_err(burst_err),
    .stall_cnt_flat(stall_cnt_flat)
  );

  typedef struct {
    logic [1:0] valid;
    logic [1:0] last;
    logic [1:0] exp_ready;
    logic       exp_we;
    logic       exp_busy;
    logic       exp_grant;
    logic [8:0] exp_addr;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    rd_lock   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int pulses;
    int pulse_cyc;
    int w0;
    logic [8:0]  cap_addr;
    logic [39:0] cap_data;

    tbl[0]  = '{2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 9'h000};
    tbl[1]  = '{2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 9'h000};
    tbl[2]  = '{2'b11, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 9'h011};
    tbl[3]  = '{2'b11, 2'b11, 2'b01, 1'b1, 1'b1, 1'b0, 9'h011};
    tbl[4]  = '{2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 9'h011};
    tbl[5]  = '{2'b11, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 9'h011};
    tbl[6]  = '{2'b11, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 9'h122};
    tbl[7]  = '{2'b11, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 9'h122};
    tbl[8]  = '{2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 9'h122};
    tbl[9]  = '{2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 9'h122};
    tbl[10] = '{2'b11, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 9'h011};
    tbl[11] = '{2'b11, 2'b11, 2'b01, 1'b1, 1'b1, 1'b0, 9'h011};
    tbl[12] = '{2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 9'h011};

    rst = 1'b1; req_valid = '0; req_last = '0; rd_lock = 1'b0;
    req_addr = '0; req_data = '0;
    @(negedge clk);
    chk("rst_we", page_ram_we, 0);
    chk("rst_addr", page_ram_wr_addr, 0);
    chk("rst_data", page_ram_wr_data, 0);
    chk("rst_grant", grant_lane, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", burst_err, 0);
    chk("rst_stall", stall_cnt_flat, 0);
    chk("rst_ready", req_ready, 0);

    // Two lanes, 3-beat bursts, alternating grants
    do_reset();
    req_addr = {9'h122, 9'h011};
    for (int r = 0; r < 13; r++) begin
      next_cycle();
      req_valid = tbl[r].valid;
      req_last  = tbl[r].last;
      @(negedge clk);
      chk($sformatf("alt_ready[%0d]", r), req_ready, tbl[r].exp_ready);
      chk($sformatf("alt_we[%0d]", r), page_ram_we, tbl[r].exp_we);
      chk($sformatf("alt_busy[%0d]", r), busy, tbl[r].exp_busy);
      chk($sformatf("alt_grant[%0d]", r), grant_lane, tbl[r].exp_grant);
      chk($sformatf("alt_addr[%0d]", r), page_ram_wr_addr, tbl[r].exp_addr);
    end

    // Single beat on lane 1
    do_reset();
    req_addr = {9'h1A5, 9'h000};
    req_data = {40'h12_3456_789A, 40'h0};
    pulses = 0; pulse_cyc = -1; cap_addr = '0; cap_data = '0;
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      req_valid = (c < 2) ? 2'b10 : 2'b00;
      req_last  = 2'b10;
      @(negedge clk);
      if (page_ram_we) begin
        pulses++;
        pulse_cyc = c;
        cap_addr  = page_ram_wr_addr;
        cap_data  = page_ram_wr_data;
      end
    end
    chk("one_pulses", pulses, 1);
    chk("one_latency", pulse_cyc, 2);
    chk("one_addr", cap_addr, 9'h1A5);
    chk("one_data", cap_data, 40'h12_3456_789A);

    // rd_lock holds off the grant
    do_reset();
    req_addr = '0; req_data = '0;
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      req_valid = 2'b01;
      rd_lock   = (c < 5);
      @(negedge clk);
      if (c < 5) begin
        chk($sformatf("lock_blk[%0d]", c), wr_blocked_by_rd_lock, 1);
        chk($sformatf("lock_busy[%0d]", c), busy, 0);
      end else if (c == 5) begin
        chk("lock_blk_off", wr_blocked_by_rd_lock, 0);
        chk("lock_stall", stall_cnt_flat[15:0], 5);
      end else begin
        chk("lock_grant_busy", busy, 1);
        chk("lock_grant_ready", req_ready, 2'b01);
      end
    end
    rd_lock = 1'b0;

    // Lane 0 never sends last: forced cut at MAX_BURST
    do_reset();
    req_addr = {9'h1F0, 9'h040};
    req_data = {40'hBB_0000_0001, 40'hAA_0000_0000};
    w0 = 0;
    for (int c = 0; c < 21; c++) begin
      next_cycle();
      req_valid = {(c <= 18), 1'b1};
      req_last  = 2'b10;
      @(negedge clk);
      if (c <= 17 && page_ram_we && page_ram_wr_addr == 9'h040) w0++;
      if (c == 16) chk("cut_err_pre", burst_err, 0);
      if (c == 17) begin
        chk("cut_writes", w0, 16);
        chk("cut_err", burst_err, 1);
        chk("cut_idle", busy, 0);
      end
      if (c == 18) begin
        chk("cut_next_grant", grant_lane, 1);
        chk("cut_next_ready", req_ready, 2'b10);
        chk("cut_stall1", stall_cnt_flat[31:16], 18);
      end
      if (c == 19) begin
        chk("cut_l1_we", page_ram_we, 1);
        chk("cut_l1_addr", page_ram_wr_addr, 9'h1F0);
      end
      if (c == 20) begin
        chk("cut_regrant", grant_lane, 0);
        chk("cut_regrant_busy", busy, 1);
        chk("cut_err_sticky", burst_err, 1);
      end
    end

    // Reset in the middle of beat 2
    do_reset();
    req_addr = {9'h0BB, 9'h0AA};
    req_data = {40'h0, 40'h55_5555_5555};
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      req_valid = 2'b01;
      req_last  = 2'b00;
    end
    next_cycle();
    #1 rst = 1'b1;
    #1;
    chk("mid_we", page_ram_we, 0);
    chk("mid_addr", page_ram_wr_addr, 0);
    chk("mid_data", page_ram_wr_data, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", req_ready, 0);
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (page_ram_we) pulses++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    if (page_ram_we) pulses++;
    next_cycle();
    @(negedge clk);
    if (page_ram_we) pulses++;
    chk("mid_no_pulse", pulses, 0);
    chk("mid_first_ready", req_ready, 2'b01);
    chk("mid_first_grant", grant_lane, 0);

    // Stall counter saturation
    do_reset();
    next_cycle();
    rd_lock   = 1'b1;
    req_valid = 2'b01;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("sat_pre", stall_cnt_flat[15:0], 16'hFFFE);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("sat_stick", stall_cnt_flat[15:0], 16'hFFFF);
    chk("sat_other", stall_cnt_flat[31:16], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
